hier_node_fanin_arbiter: RTL and testbench

- Upstream (fan-in) counterpart of the generated hierarchy node, which fans one parent out to NUM_CHILD child instances.
- Merges valid/ready message streams from NUM_CHILD children into one parent stream.
- Arbitration is round-robin; each forwarded word is tagged with the index of the child that sent it.
- One registered output stage decouples parent backpressure; a saturating counter records forwarded words for hierarchy-level debug.

---
 rtl/hier_node_fanin_arbiter_if.sv | 25 ++
 rtl/hier_node_fanin_arbiter.sv | 92 +++++++++
 tb/tb_hier_node_fanin_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hier_node_fanin_arbiter_if.sv
// Child fan-in and parent stream signals of the hierarchy fan-in arbiter.
// The master modport is the arbiter side and the slave modport is the environment side.
interface hier_node_fanin_arbiter_if #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 3
);
    logic [NUM_CHILD-1:0]        child_valid;
    logic [NUM_CHILD-1:0]        child_ready;
    logic [NUM_CHILD*DATA_W-1:0] child_data;
    logic                        parent_valid;
    logic                        parent_ready;
    logic [DATA_W-1:0]           parent_data;
    logic [IDX_W-1:0]            parent_idx;

    modport master (
        input  child_valid, child_data, parent_ready,
        output child_ready, parent_valid, parent_data, parent_idx
    );

    modport slave (
        output child_valid, child_data, parent_ready,
        input  child_ready, parent_valid, parent_data, parent_idx
    );
endinterface

// File: rtl/hier_node_fanin_arbiter.sv
// Round-robin fan-in of NUM_CHILD child streams into one registered parent stream,
// tagging each word with its source child and counting accepted words (saturating).
module hier_node_fanin_arbiter #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    hier_node_fanin_arbiter_if.master     bus,
    output logic [CNT_W-1:0]              fwd_count,
    output logic                          busy
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    logic              can_load;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              take;
    logic [IDX_W-1:0]  next_ptr;
    int                cand;

    assign bus.parent_valid = (state == ST_FULL);
    assign bus.parent_data  = out_data;
    assign bus.parent_idx   = out_idx;
    assign can_load         = (state == ST_EMPTY) || bus.parent_ready;
    assign busy             = bus.parent_valid || (|bus.child_valid);

    // Search from rr_ptr upward with wrap; the first valid child wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        cand        = 0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CHILD) begin
                cand = cand - NUM_CHILD;
            end
            if (!grant_found && bus.child_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_data  = bus.child_data[cand*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.child_ready = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            bus.child_ready[i] = can_load && grant_found && (grant_idx == IDX_W'(i));
        end
    end

    assign take     = can_load && grant_found;
    assign next_ptr = (grant_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : grant_idx + IDX_W'(1);

    // A load and a pop in the same cycle keep the register FULL for back-to-back words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_idx  <= '0;
            rr_ptr   <= '0;
        end else if (take) begin
            state    <= ST_FULL;
            out_data <= grant_data;
            out_idx  <= grant_idx;
            rr_ptr   <= next_ptr;
        end else if (bus.parent_ready) begin
            state    <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count <= '0;
        end else if (take && (fwd_count != {CNT_W{1'b1}})) begin
            fwd_count <= fwd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hier_node_fanin_arbiter.sv
// Scoreboard bench for hier_node_fanin_arbiter: per-child queues feed the DUT,
// expected words are queued by hand and popped by a monitor on each parent transfer.
module tb_hier_node_fanin_arbiter;

    localparam int NC    = 5;
    localparam int DW    = 32;
    localparam int IW    = 3;
    localparam int CW    = 4;

    typedef struct {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [CW-1:0] fwd_count;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] child_q[NC][$];
    logic [NC-1:0] accepted;

    hier_node_fanin_arbiter_if #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW)) bus ();

    hier_node_fanin_arbiter #(
        .NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .fwd_count (fwd_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int child, input logic [DW-1:0] word);
        child_q[child].push_back(word);
    endtask

    task automatic expectWord(input int child, input logic [DW-1:0] word);
        exp_t e;
        e.idx  = IW'(child);
        e.data = word;
        exp_q.push_back(e);
    endtask

    function automatic bit childPending();
        for (int i = 0; i < NC; i++) begin
            if (child_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic waitDrain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || bus.parent_valid || childPending()) && n < limit) begin
            step();
            n++;
        end
        checkOutput(name, 64'(n < limit), 64'(1));
    endtask

    task automatic resetDut();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NC; i++) child_q[i].delete();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Child driver: present the head of each queue, retire it once ready was seen.
    initial begin
        accepted         = '0;
        bus.child_valid  = '0;
        bus.child_data   = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (accepted[i] && child_q[i].size() != 0) void'(child_q[i].pop_front());
            end
            for (int i = 0; i < NC; i++) begin
                if (child_q[i].size() != 0) begin
                    bus.child_valid[i]          = 1'b1;
                    bus.child_data[i*DW +: DW]  = child_q[i][0];
                end else begin
                    bus.child_valid[i]          = 1'b0;
                end
            end
            #4;
            for (int i = 0; i < NC; i++) accepted[i] = bus.child_ready[i] && !rst;
        end
    end

    // Monitor: just before each rising edge, a parent transfer pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && bus.parent_valid && bus.parent_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 64'(bus.parent_idx), 64'hFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_idx", 64'(bus.parent_idx), 64'(e.idx));
                    checkOutput("sb_data", 64'(bus.parent_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.parent_ready = 1'b1;
        repeat (3) step();
        checkOutput("rst_parent_valid", 64'(bus.parent_valid), 64'(0));
        checkOutput("rst_parent_data", 64'(bus.parent_data), 64'(0));
        checkOutput("rst_parent_idx", 64'(bus.parent_idx), 64'(0));
        checkOutput("rst_fwd_count", 64'(fwd_count), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        step();

        // Load a word from child 1 (pointer moves to 2), then reset it away.
        bus.parent_ready = 1'b0;
        applyStimulus(1, 32'h1111_0001);
        step();
        step();
        checkOutput("pre_rst_parent_valid", 64'(bus.parent_valid), 64'(1));
        checkOutput("pre_rst_fwd_count", 64'(fwd_count), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NC; i++) child_q[i].delete();
        #1;
        checkOutput("async_rst_parent_valid", 64'(bus.parent_valid), 64'(0));
        checkOutput("async_rst_fwd_count", 64'(fwd_count), 64'(0));
        step();
        step();
        rst              = 1'b0;
        bus.parent_ready = 1'b1;
        step();
        applyStimulus(0, 32'h0000_00A0);
        applyStimulus(3, 32'h0000_00A3);
        expectWord(0, 32'h0000_00A0);
        expectWord(3, 32'h0000_00A3);
        waitDrain("drain_after_reset", 20);

        // Single source with one-cycle latency; the next search starts at child 3.
        applyStimulus(2, 32'hA5A5_0001);
        expectWord(2, 32'hA5A5_0001);
        @(negedge clk);
        #4;
        checkOutput("single_child_ready", 64'(bus.child_ready), 64'(5'b00100));
        step();
        checkOutput("single_parent_valid", 64'(bus.parent_valid), 64'(1));
        checkOutput("single_parent_data", 64'(bus.parent_data), 64'hA5A5_0001);
        checkOutput("single_parent_idx", 64'(bus.parent_idx), 64'(2));
        waitDrain("drain_single", 20);
        applyStimulus(1, 32'hB000_0001);
        applyStimulus(3, 32'hB000_0003);
        expectWord(3, 32'hB000_0003);
        expectWord(1, 32'hB000_0001);
        waitDrain("drain_after_single", 20);
        checkOutput("idle_busy", 64'(busy), 64'(0));

        // All five children, two words each, must stream one word per cycle.
        resetDut();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) begin
                applyStimulus(i, 32'hC000_0000 | (i << 8) | k);
                expectWord(i, 32'hC000_0000 | (i << 8) | k);
            end
        end
        repeat (11) @(negedge clk);
        #1;
        checkOutput("stream_fwd_count", 64'(fwd_count), 64'(10));
        checkOutput("stream_parent_idx", 64'(bus.parent_idx), 64'(4));
        checkOutput("stream_busy", 64'(busy), 64'(1));
        waitDrain("drain_stream", 20);

        // Backpressure: hold child 0's word while children 1 and 3 wait.
        bus.parent_ready = 1'b0;
        applyStimulus(0, 32'hD000_0000);
        expectWord(0, 32'hD000_0000);
        step();
        step();
        applyStimulus(1, 32'hD000_0001);
        applyStimulus(3, 32'hD000_0003);
        expectWord(1, 32'hD000_0001);
        expectWord(3, 32'hD000_0003);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #4;
            checkOutput("bp_child_ready", 64'(bus.child_ready), 64'(0));
            checkOutput("bp_parent_valid", 64'(bus.parent_valid), 64'(1));
            checkOutput("bp_parent_idx", 64'(bus.parent_idx), 64'(0));
            checkOutput("bp_parent_data", 64'(bus.parent_data), 64'hD000_0000);
        end
        step();
        bus.parent_ready = 1'b1;
        waitDrain("drain_backpressure", 20);
        checkOutput("bp_fwd_count", 64'(fwd_count), 64'(13));

        // Wrap/skip: pointer at 4, only child 1 valid; pointer then sits at 2.
        applyStimulus(3, 32'hE000_0003);
        expectWord(3, 32'hE000_0003);
        waitDrain("drain_wrap_setup", 20);
        applyStimulus(1, 32'hE000_0001);
        expectWord(1, 32'hE000_0001);
        waitDrain("drain_wrap", 20);
        applyStimulus(1, 32'hE100_0001);
        applyStimulus(2, 32'hE100_0002);
        expectWord(2, 32'hE100_0002);
        expectWord(1, 32'hE100_0001);
        waitDrain("drain_wrap_order", 20);

        // Saturation of the 4-bit forwarded-word counter.
        resetDut();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 32'hF000_0000 | k);
            expectWord(0, 32'hF000_0000 | k);
        end
        waitDrain("drain_saturate", 60);
        checkOutput("sat_fwd_count", 64'(fwd_count), 64'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
